sram_bank_array: RTL and testbench

//  Slave side of sram_if: single-port, byte-maskable SRAM tiled from BANK_NUM banks.

---
 rtl/sram_bank_array_pkg.sv | 20 ++
 rtl/sram_bank_array_if.sv | 33 +++
 rtl/sram_bank_array_bank.sv | 56 +++++
 rtl/sram_bank_array.sv | 130 +++++++++++++
 tb/tb_sram_bank_array.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_bank_array_pkg.sv
// Shared types and defaults for the banked SRAM slave.
// SRAM_PARITY_EN adds per-byte even parity.
package sram_bank_array_pkg;

  localparam int SRAM_DATA_WIDTH = 64;
  localparam int SRAM_ADDR_WIDTH = 32;
  localparam int SRAM_BANK_NUM   = 4;
  localparam int SRAM_BANK_DEPTH = 1024;

  typedef enum logic [1:0] {
    INIT_IDLE = 2'd0,
    INIT_CLR  = 2'd1,
    INIT_DONE = 2'd2
  } init_state_t;

  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_bank_array_if.sv
// Strobe bus between the memory controller and the SRAM array.
// SRAM_PARITY_EN adds par_err_o.
interface sram_bank_array_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                    en_i;
  logic                    wen_i;
  logic [DATA_WIDTH/8-1:0] bm_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    init_done_o;
`ifdef SRAM_PARITY_EN
  logic                    par_err_o;
`endif

  modport master (
`ifdef SRAM_PARITY_EN
    input  par_err_o,
`endif
    output en_i, wen_i, bm_i, addr_i, dat_i,
    input  dat_o, init_done_o
  );

  modport slave (
`ifdef SRAM_PARITY_EN
    output par_err_o,
`endif
    input  en_i, wen_i, bm_i, addr_i, dat_i,
    output dat_o, init_done_o
  );
endinterface

// File: rtl/sram_bank_array_bank.sv
// sram_bank: one behavioural byte-maskable bank, registered read port.
// SRAM_PARITY_EN stores one parity bit per byte.
module sram_bank
  import sram_bank_array_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  localparam int NB        = DATA_WIDTH / 8,
  localparam int RW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce_n,
  input  logic                  we_n,
  input  logic [NB-1:0]         bm_n,
  input  logic [RW-1:0]         row,
  input  logic [DATA_WIDTH-1:0] din,
`ifdef SRAM_PARITY_EN
  output logic [NB-1:0]         dout_par,
`endif
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!ce_n && !we_n) begin
      for (int k = 0; k < NB; k++) begin
        if (!bm_n[k]) mem[row][k*8 +: 8] <= din[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else if (!ce_n && we_n) dout <= mem[row];
  end

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  always_ff @(posedge clk) begin
    if (!ce_n && !we_n) begin
      for (int k = 0; k < NB; k++) begin
        if (!bm_n[k]) par[row][k] <= byte_par(din[k*8 +: 8]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_par <= '0;
    else if (!ce_n && we_n) dout_par <= par[row];
  end
`endif

endmodule

// File: rtl/sram_bank_array.sv
// sram_bank_array: banked byte-maskable SRAM slave with post-reset clear.
// SRAM_PARITY_EN enables per-byte parity and par_err_o.
module sram_bank_array
  import sram_bank_array_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int BANK_NUM   = SRAM_BANK_NUM,
  parameter int BANK_DEPTH = SRAM_BANK_DEPTH
) (
  input logic              aclk_i,
  input logic              aresetn_i,
  sram_bank_array_if.slave bus
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int RW  = $clog2(BANK_DEPTH);
  localparam int BW  = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  init_state_t state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row, row_s;
  logic [BW-1:0] bank, bank_q;
  logic clr, acc, rd;
  logic we_s;
  logic [NB-1:0] bm_s;
  logic [DATA_WIDTH-1:0] din_s;
  logic [DATA_WIDTH-1:0] dout [BANK_NUM];
  logic unused_addr;

  // Upper address bits alias silently.
  assign row = bus.addr_i[OFF +: RW];
  assign unused_addr = ^bus.addr_i;

  generate
    if (BANK_NUM > 1) begin : g_bsel
      assign bank = bus.addr_i[OFF+RW +: BW];
    end else begin : g_bone
      assign bank = '0;
    end
  endgenerate

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= INIT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT_IDLE: state_d = INIT_CLR;
      INIT_CLR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RW'(BANK_DEPTH - 1)) state_d = INIT_DONE;
      end
      INIT_DONE: state_d = INIT_DONE;
      default:   state_d = INIT_IDLE;
    endcase
  end

  // External strobes only count once the array has been cleared.
  assign clr   = (state_q == INIT_CLR);
  assign acc   = (state_q == INIT_DONE) && !bus.en_i;
  assign rd    = acc && bus.wen_i;
  assign we_s  = clr ? 1'b0 : bus.wen_i;
  assign bm_s  = clr ? '0 : bus.bm_i;
  assign row_s = clr ? cnt_q : row;
  assign din_s = clr ? '0 : bus.dat_i;

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] dpar [BANK_NUM];
`endif

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    logic ce_n;
    assign ce_n = !(clr || (acc && bank == BW'(b)));
    sram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BANK_DEPTH)
    ) u_bank (
      .clk      (aclk_i),
      .rst_n    (aresetn_i),
      .ce_n     (ce_n),
      .we_n     (we_s),
      .bm_n     (bm_s),
      .row      (row_s),
      .din      (din_s),
`ifdef SRAM_PARITY_EN
      .dout_par (dpar[b]),
`endif
      .dout     (dout[b])
    );
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) bank_q <= '0;
    else if (rd) bank_q <= bank;
  end

  assign bus.dat_o       = dout[bank_q];
  assign bus.init_done_o = (state_q == INIT_DONE);

`ifdef SRAM_PARITY_EN
  logic rd_q;
  logic [NB-1:0] pmis;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) rd_q <= 1'b0;
    else rd_q <= rd;
  end

  always_comb begin
    pmis = '0;
    for (int k = 0; k < NB; k++) begin
      pmis[k] = byte_par(dout[bank_q][k*8 +: 8]) ^ dpar[bank_q][k];
    end
  end

  // Error is a one-cycle flag on the read result, quiet during hold.
  assign bus.par_err_o = rd_q && (|pmis);
`endif

endmodule

// File: tb/tb_sram_bank_array.sv
// Self-checking bench for sram_bank_array: vector table, scoreboard queue,
// and hand-written reset / hold / bank-walk sequences.
module tb_sram_bank_array;
  import sram_bank_array_pkg::*;

  localparam int DEPTH = 1024;
  localparam int NBANK = 4;
  localparam int WORDS = DEPTH * NBANK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_bank_array_if bus ();

  sram_bank_array dut (
    .aclk_i    (clk),
    .aresetn_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    bit          rd;
    logic [7:0]  bm;
    logic [31:0] addr;
    logic [63:0] dat;
    logic [63:0] exp;
    string       nm;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  logic [63:0] model [WORDS];
  logic [63:0] exp_q [$];
  string nm_q [$];
  vec_t vt [11];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic int key(input logic [31:0] a);
    return int'((a >> 3) & 32'(WORDS - 1));
  endfunction

  task automatic model_wr(input logic [7:0] bm, input logic [31:0] a,
                          input logic [63:0] d);
    for (int k = 0; k < 8; k++)
      if (!bm[k]) model[key(a)][k*8 +: 8] = d[k*8 +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < WORDS; i++) model[i] = '0;
  endtask

  task automatic op(input bit rd, input logic [7:0] bm,
                    input logic [31:0] a, input logic [63:0] d,
                    input logic [63:0] exp, input string nm);
    @(negedge clk);
    bus.en_i   = 1'b0;
    bus.wen_i  = rd;
    bus.bm_i   = bm;
    bus.addr_i = a;
    bus.dat_i  = d;
    if (rd) begin
      exp_q.push_back(exp);
      nm_q.push_back(nm);
    end else begin
      model_wr(bm, a, d);
    end
    @(posedge clk);
    #1;
    if (rd) begin
      check(nm_q.pop_front(), bus.dat_o, exp_q.pop_front());
`ifdef SRAM_PARITY_EN
      check("par_err_clean", 64'(bus.par_err_o), 64'd0);
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.en_i = 1'b1;
    end
  endtask

  // Counts posedges from reset release until init_done_o rises.
  task automatic wait_init(output int n, input bit poke);
    n = 0;
    while (!bus.init_done_o && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 8) bus.en_i = 1'b1;
    end
  endtask

  initial begin
    int n;
    logic [63:0] held;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0] bm;
    bit rd;

    vt[0]  = '{0, 8'h00, 32'h0,  64'h0123_4567_89AB_CDEF, 64'h0, "wr0"};
    vt[1]  = '{1, 8'hFF, 32'h0,  64'h0, 64'h0123_4567_89AB_CDEF, "wr_rd_full"};
    vt[2]  = '{0, 8'hF0, 32'h8,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, "wr1"};
    vt[3]  = '{1, 8'hFF, 32'h8,  64'h0, 64'h0000_0000_FFFF_FFFF, "bm_low"};
    vt[4]  = '{0, 8'hFE, 32'h10, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, "wr2"};
    vt[5]  = '{1, 8'hFF, 32'h10, 64'h0, 64'h0000_0000_0000_00AA, "bm_byte0"};
    vt[6]  = '{0, 8'hFF, 32'h10, 64'h5555_5555_5555_5555, 64'h0, "wr3"};
    vt[7]  = '{1, 8'hFF, 32'h10, 64'h0, 64'h0000_0000_0000_00AA, "bm_none"};
    vt[8]  = '{0, 8'h00, 32'h18, 64'h1122_3344_5566_7788, 64'h0, "wr4"};
    vt[9]  = '{1, 8'hFF, 32'h18, 64'h0, 64'h1122_3344_5566_7788, "wr_then_rd"};
    vt[10] = '{1, 8'hFF, 32'h5,  64'h0, 64'h0123_4567_89AB_CDEF, "byte_off"};

    bus.en_i = 1'b1;
    bus.wen_i = 1'b1;
    bus.bm_i = '1;
    bus.addr_i = '0;
    bus.dat_i = '0;

    #12;
    check("rst_dat", bus.dat_o, 64'd0);
    check("rst_done", 64'(bus.init_done_o), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n, 1'b0);
    check("init_len", 64'(n), 64'(DEPTH + 1));
    model_clear();

    for (int w = 0; w < WORDS; w++) op(1, 8'hFF, 32'(w * 8), 64'h0, 64'h0, "clear");

    for (int i = 0; i < 11; i++)
      op(vt[i].rd, vt[i].bm, vt[i].addr, vt[i].dat, vt[i].exp, vt[i].nm);

    // Idle hold, with one write slipped in that must not disturb dat_o.
    op(1, 8'hFF, 32'h0, 64'h0, 64'h0123_4567_89AB_CDEF, "hold_rd");
    held = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.en_i = (i == 5) ? 1'b0 : 1'b1;
      bus.wen_i = (i == 5) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.bm_i = 8'h00;
      bus.addr_i = (i == 5) ? 32'h20 : $urandom;
      bus.dat_i = {$urandom, $urandom};
      if (i == 5) model_wr(8'h00, 32'h20, bus.dat_i);
      @(posedge clk);
      #1;
      check("hold", bus.dat_o, held);
    end

    for (int b = 0; b < NBANK; b++)
      op(0, 8'h00, 32'((DEPTH * b + 5) * 8), 64'(b), 64'h0, "walk_wr");
    for (int b = 0; b < NBANK; b++)
      op(1, 8'hFF, 32'((DEPTH * b + 5) * 8), 64'h0, 64'(b), "bank_walk");

    op(0, 8'h00, 32'(WORDS * 8), 64'hDEAD_BEEF_CAFE_F00D, 64'h0, "alias_wr");
    op(1, 8'hFF, 32'h0, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, "alias_lo");
    op(1, 8'hFF, 32'(WORDS * 8), 64'h0, 64'hDEAD_BEEF_CAFE_F00D, "alias_hi");
    idle(2);

    for (int i = 0; i < 300; i++) begin
      rd = 1'($urandom_range(0, 1));
      a = 32'(($urandom_range(0, 3) * DEPTH + $urandom_range(0, 7)) * 8
            + $urandom_range(0, 1) * WORDS * 8);
      d = {$urandom, $urandom};
      bm = 8'($urandom);
      op(rd, rd ? 8'hFF : bm, a, d, model[key(a)], "rand");
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    op(1, 8'hFF, 32'h0, 64'h0, model[0], "pre_rst");
    #3;
    bus.en_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_async_dat", bus.dat_o, 64'd0);
    check("rst_async_done", 64'(bus.init_done_o), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) @(posedge clk);
    #2;
    check("midclr_done_low", 64'(bus.init_done_o), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midclr_dat", bus.dat_o, 64'd0);
    check("midclr_done", 64'(bus.init_done_o), 64'd0);

    // Writes attempted during the clear must be ignored.
    @(negedge clk);
    bus.en_i = 1'b0;
    bus.wen_i = 1'b0;
    bus.bm_i = 8'h00;
    bus.addr_i = 32'h28;
    bus.dat_i = '1;
    rst_n = 1'b1;
    wait_init(n, 1'b1);
    check("reinit_len", 64'(n), 64'(DEPTH + 1));
    model_clear();

    op(1, 8'hFF, 32'h0,  64'h0, 64'h0, "reclr_0");
    op(1, 8'hFF, 32'h18, 64'h0, 64'h0, "reclr_18");
    op(1, 8'hFF, 32'h28, 64'h0, 64'h0, "clr_ignores_en");
    op(1, 8'hFF, 32'((DEPTH * 3 + 5) * 8), 64'h0, 64'h0, "reclr_b3");
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
